// File: rtl/key_debounce_multi_if.sv
// Key debouncer bus: raw key pins in, debounced level and event pulses out.
//   key_in       : raw asynchronous key pins, bit i = channel i
//   key_state    : debounced level per channel, 1 = pressed
//   press_flag   : one-cycle pulse when a press is accepted
//   release_flag : one-cycle pulse when a release is accepted
//   long_flag    : one-cycle pulse once per press after the long-hold time
// master = the side that owns the pins and consumes the events
// slave  = the debouncer
interface key_debounce_multi_if #(
  parameter int KEY_NUM = 4
);
  logic [KEY_NUM-1:0] key_in;
  logic [KEY_NUM-1:0] key_state;
  logic [KEY_NUM-1:0] press_flag;
  logic [KEY_NUM-1:0] release_flag;
  logic [KEY_NUM-1:0] long_flag;

  modport master (
    output key_in,
    input  key_state,
    input  press_flag,
    input  release_flag,
    input  long_flag
  );

  modport slave (
    input  key_in,
    output key_state,
    output press_flag,
    output release_flag,
    output long_flag
  );
endinterface

// File: rtl/key_debounce_multi.sv
// Multi-channel push-button debouncer. Each channel independently:
//   - synchronises its raw pin through two flops,
//   - accepts a level change only after CNT_MAX+1 consecutive differing samples,
//   - pulses press/release for one cycle on each accepted change,
//   - pulses long once per press after the key has been held LONG_MAX cycles.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : key_debounce_multi_if.slave (key_in in; key_state, press_flag,
//           release_flag, long_flag out)
// All outputs are registered; there is no combinational path from key_in.
module key_debounce_multi #(
  parameter int KEY_NUM    = 4,
  parameter int CNT_MAX    = 999_999,
  parameter int LONG_MAX   = 49_999_999,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  key_debounce_multi_if.slave   bus
);

  // CNT_MAX=0 would give a zero-width counter; keep at least one bit.
  localparam int CW = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
  localparam int HW = $clog2(LONG_MAX + 1);

  localparam logic [CW-1:0] CNT_TOP   = CW'(CNT_MAX);
  localparam logic [HW-1:0] HOLD_TOP  = HW'(LONG_MAX);
  localparam logic [HW-1:0] HOLD_FIRE = HW'(LONG_MAX - 1);
  // Pin level of a released key; sync flops reset to it so reset itself
  // never looks like an edge.
  localparam logic          IDLE      = (ACTIVE_LOW != 0);

  // Saturating increment for the hold counter: once the long-hold time is
  // reached the counter parks at LONG_MAX so the fire compare cannot repeat.
  function automatic logic [HW-1:0] hold_sat_inc(input logic [HW-1:0] h);
    if (h == HOLD_TOP) begin
      return h;
    end
    return h + HW'(1);
  endfunction

  logic [KEY_NUM-1:0] sync_p0;
  logic [KEY_NUM-1:0] sync_p1;
  logic [KEY_NUM-1:0] raw;
  logic [KEY_NUM-1:0] state;
  logic [KEY_NUM-1:0] press;
  logic [KEY_NUM-1:0] rel;
  logic [KEY_NUM-1:0] lng;
  logic [CW-1:0]      cnt  [KEY_NUM];
  logic [HW-1:0]      hcnt [KEY_NUM];

  // ---- Stage: two-flop synchroniser on the raw pins ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= {KEY_NUM{IDLE}};
      sync_p1 <= {KEY_NUM{IDLE}};
    end else begin
      sync_p0 <= bus.key_in;
      sync_p1 <= sync_p0;
    end
  end

  // Normalise polarity so raw=1 always means pressed.
  assign raw = (ACTIVE_LOW != 0) ? ~sync_p1 : sync_p1;

  // ---- Stage: stability filter, debounced level and edge pulses ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= '0;
      press <= '0;
      rel   <= '0;
      for (int i = 0; i < KEY_NUM; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      press <= '0;
      rel   <= '0;
      for (int i = 0; i < KEY_NUM; i++) begin
        if (raw[i] == state[i]) begin
          // Any agreeing sample restarts filtering, discarding short bounces.
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_TOP) begin
          state[i] <= raw[i];
          cnt[i]   <= '0;
          press[i] <= raw[i];
          rel[i]   <= ~raw[i];
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  // ---- Stage: hold timer and long-press pulse ----
  // hcnt counts edges since key_state rose; comparing against LONG_MAX-1
  // makes long_flag appear exactly LONG_MAX edges after acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lng <= '0;
      for (int i = 0; i < KEY_NUM; i++) begin
        hcnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < KEY_NUM; i++) begin
        if (!state[i]) begin
          hcnt[i] <= '0;
        end else begin
          hcnt[i] <= hold_sat_inc(hcnt[i]);
        end
        lng[i] <= state[i] && (hcnt[i] == HOLD_FIRE);
      end
    end
  end

  assign bus.key_state    = state;
  assign bus.press_flag   = press;
  assign bus.release_flag = rel;
  assign bus.long_flag    = lng;

endmodule
